// File: rtl/pipeline_pkg.sv
// Types and constants shared by the decode controller and the ID/EX pipeline register.
package pipeline_pkg;

   localparam int DATA_W_DEF = 32;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       branch;
      logic       jalr_sel;
   } ctrl_t;

   typedef enum logic [6:0] {
      R_TYPE = 7'b0110011,
      I_TYPE = 7'b0010011,
      LW     = 7'b0000011,
      SW     = 7'b0100011,
      BR     = 7'b1100011,
      JAL    = 7'b1101111
   } opcode_e;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
      return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register, plus hazard status.
interface id_ex_stage_if
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              id_valid;
   ctrl_t             id_ctrl;
   logic [DATA_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [2:0]        id_funct3;
   logic [6:0]        id_funct7;
   logic              flush;

   logic              ex_valid;
   ctrl_t             ex_ctrl;
   logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [2:0]        ex_funct3;
   logic [6:0]        ex_funct7;
   logic              stall;
   logic [15:0]       stall_cnt, flush_cnt;

   modport slave (
      input  id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
      output ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
             stall, stall_cnt, flush_cnt
   );

   modport master (
      output id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
      input  ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
             stall, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       load_use
);

   // Both sources are compared even for formats that ignore rs2; the extra bubble is harmless.
   assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating event counters.
module id_ex_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_stage_if.slave  bus
);

   logic              load_use;
   logic              nxt_valid;
   ctrl_t             nxt_ctrl;
   logic [DATA_W-1:0] nxt_pc, nxt_rd1, nxt_rd2, nxt_imm;
   logic [4:0]        nxt_rs1, nxt_rs2, nxt_rd;
   logic [2:0]        nxt_funct3;
   logic [6:0]        nxt_funct7;

   hazard_detect u_hazard (
      .ex_valid    (bus.ex_valid),
      .ex_mem_read (bus.ex_ctrl.mem_read),
      .ex_rd       (bus.ex_rd),
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .load_use    (load_use)
   );

   // A flush already discards the ID instruction, so it must not also freeze fetch.
   assign bus.stall = load_use & ~bus.flush;

   always_comb begin
      // NOTE: every output gets a default (the bubble) first so no path leaves a latch.
      nxt_valid  = 1'b0;
      nxt_ctrl   = '0;
      nxt_pc     = '0;
      nxt_rd1    = '0;
      nxt_rd2    = '0;
      nxt_imm    = '0;
      nxt_rs1    = '0;
      nxt_rs2    = '0;
      nxt_rd     = '0;
      nxt_funct3 = '0;
      nxt_funct7 = '0;
      if (!(bus.flush || load_use)) begin
         nxt_valid  = bus.id_valid;
         nxt_ctrl   = bus.id_valid ? bus.id_ctrl : '0;
         nxt_pc     = bus.id_pc;
         nxt_rd1    = bus.id_rd1;
         nxt_rd2    = bus.id_rd2;
         nxt_imm    = bus.id_imm;
         nxt_rs1    = bus.id_rs1;
         nxt_rs2    = bus.id_rs2;
         nxt_rd     = bus.id_rd;
         nxt_funct3 = bus.id_funct3;
         nxt_funct7 = bus.id_funct7;
      end
   end

   // NOTE: every stage register is cleared asynchronously so nothing in flight survives reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ex_valid  <= 1'b0;
         bus.ex_ctrl   <= '0;
         bus.ex_pc     <= '0;
         bus.ex_rd1    <= '0;
         bus.ex_rd2    <= '0;
         bus.ex_imm    <= '0;
         bus.ex_rs1    <= '0;
         bus.ex_rs2    <= '0;
         bus.ex_rd     <= '0;
         bus.ex_funct3 <= '0;
         bus.ex_funct7 <= '0;
         bus.stall_cnt <= '0;
         bus.flush_cnt <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of its peers.
         bus.ex_valid  <= nxt_valid;
         bus.ex_ctrl   <= nxt_ctrl;
         bus.ex_pc     <= nxt_pc;
         bus.ex_rd1    <= nxt_rd1;
         bus.ex_rd2    <= nxt_rd2;
         bus.ex_imm    <= nxt_imm;
         bus.ex_rs1    <= nxt_rs1;
         bus.ex_rs2    <= nxt_rs2;
         bus.ex_rd     <= nxt_rd;
         bus.ex_funct3 <= nxt_funct3;
         bus.ex_funct7 <= nxt_funct7;
         bus.stall_cnt <= sat_inc(bus.stall_cnt, bus.stall);
         bus.flush_cnt <= sat_inc(bus.flush_cnt, bus.flush);
      end
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and PC width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_ctrl  input  ctrl_t  decoded controls: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalrSel.
REQ-006 id_pc, id_rd1, id_rd2, id_imm  input  DATA_W each  PC, register-file read data, extended immediate.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  register indices; id_funct3  input  3; id_funct7  input  7.
REQ-008 flush  input  1  branch/jump taken in EX; the ID instruction is wrong-path.
REQ-009 ex_valid  output  1; ex_ctrl  output  ctrl_t; ex_pc, ex_rd1, ex_rd2, ex_imm  output  DATA_W; ex_rs1, ex_rs2, ex_rd  output  5; ex_funct3  output  3; ex_funct7  output  7  registered EX-stage copies.
REQ-010 stall  output  1  combinational; holds PC and IF/ID register this cycle.
REQ-011 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-012 load_use = ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2); comparison on both sources is conservative and intended.
REQ-013 stall SHALL equal load_use & ~flush.
REQ-014 Per rising edge, exactly one action in priority order: flush -> bubble; load_use -> bubble; otherwise -> load.
REQ-015 Load: every ex_* output captures its id_* counterpart; ex_valid <= id_valid.
REQ-016 Bubble: ex_valid <= 0, all ex_ctrl fields <= 0, all data/index outputs <= 0.
REQ-017 When id_valid = 0 on a load, ex_ctrl SHALL be forced to 0 regardless of id_ctrl.
REQ-018 Latency: one cycle from id_* to ex_*; a stalled instruction enters EX exactly one cycle after the load-use producer, i.e. one bubble per load-use.
REQ-019 Back-to-back load-use never exceeds one bubble: after a bubble, ex_valid = 0, so load_use is 0 the next cycle.
REQ-020 stall_cnt increments by 1 each cycle stall = 1; flush_cnt increments each cycle flush = 1; each saturates at 16'hFFFF with no wrap.
REQ-021 flush and load_use together: one bubble, stall = 0, flush_cnt +1, stall_cnt unchanged.

Reset
REQ-022 rst_n low SHALL immediately clear ex_valid, ex_ctrl, all ex_* data/index outputs, stall_cnt and flush_cnt to 0, independent of clk.
REQ-023 While rst_n is low, stall SHALL be 0, because ex_valid = 0.
REQ-024 Reset release mid-operation: the first rising edge after release performs a normal load; no in-flight state survives reset.

Structure
REQ-025 Package pipeline_pkg: ctrl_t packed struct (fields of REQ-005), DATA_W default, opcode constants R_TYPE, I_TYPE, LW, SW, BR, JAL, shared with the decode controller.
REQ-026 Sub-module hazard_detect: combinational, computes load_use from ex_valid, ex_ctrl.MemRead, ex_rd, id_valid, id_rs1 and id_rs2.
REQ-027 Pipeline register and counters live in id_ex_stage; no latches; a single always_ff with asynchronous rst_n.

Verification
REQ-028 Reset: rst_n = 0 mid-stream with ex_valid = 1 -> all outputs 0 before next edge; stall = 0.
REQ-029 Plain load: id_valid = 1, add x3, x1, x2 (RegWrite = 1, ALUOp = 10), id_pc = 0x40 -> next cycle ex_pc = 0x40, ex_rd = 3, ex_ctrl.RegWrite = 1, stall = 0.
REQ-030 Load-use: EX holds lw x5 (MemRead = 1, ex_rd = 5), ID holds add x6, x5, x1 -> stall = 1 one cycle, bubble (ex_valid = 0), then add in EX, stall_cnt = 1.
REQ-031 x0 load: lw x0 in EX, ID reads rs1 = 0 -> stall = 0, no bubble.
REQ-032 Flush with hazard: REQ-030 setup plus flush = 1 -> stall = 0, bubble, flush_cnt = 1, stall_cnt = 0.
REQ-033 Saturation: force stall 65 540 cycles -> stall_cnt = 0xFFFF and stays at 0xFFFF.
